decode_stage: RTL and testbench

- Parametrised, pipelined RV32I/M/A decode stage between fetch and execute.
- Decodes one instruction per cycle into a packed micro-op, reads the register file, and generates the immediate.
- Detects illegal encodings and load-use hazards.
- Drives a registered ID/EX boundary with valid/ready handshakes on both sides and a synchronous flush.

---
 rtl/rv32_pkg.sv | 84 ++++++++
 rtl/decode_comb.sv | 203 ++++++++++++++++++++
 rtl/decode_stage.sv | 113 +++++++++++
 tb/tb_decode_stage.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I/M/A decode types: opcodes, micro-op fields and the packed
// micro-op handed from decode to execute.
package rv32_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [4:0] AMO_LR       = 5'b00010;

    typedef enum logic [2:0] {
        FU_NONE = 3'd0,
        FU_ALU  = 3'd1,
        FU_MUL  = 3'd2,
        FU_DIV  = 3'd3,
        FU_LSU  = 3'd4,
        FU_BRU  = 3'd5,
        FU_CSR  = 3'd6
    } fu_sel_e;

    // Encoded as {instr[30], funct3} so R-type ALU ops map directly.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } op_a_sel_e;

    typedef enum logic {
        OPB_RS2 = 1'b0,
        OPB_IMM = 1'b1
    } op_b_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        fu_sel_e     fu_sel;
        alu_op_e     alu_op;
        op_a_sel_e   op_a_sel;
        op_b_sel_e   op_b_sel;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rd_we;
        logic        mem_re;
        logic        mem_we;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        branch;
        logic        jump;
        logic [2:0]  funct3;
    } decoded_uop_t;

    localparam int UOP_W = $bits(decoded_uop_t);

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I/M/A decoder: instruction word to micro-op,
// sign-extended immediate, illegal flag and source-register usage.
module decode_comb
    import rv32_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter bit HAS_M  = 1'b1,
    parameter bit HAS_A  = 1'b1
) (
    input  logic [31:0]       instr_i,
    output logic [UOP_W-1:0]  uop_o,
    output logic [DATA_W-1:0] imm_o,
    output logic              illegal_o,
    output logic              uses_rs1_o,
    output logic              uses_rs2_o
);

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [4:0]         funct5;
    decoded_uop_t       base_uop;
    decoded_uop_t       uop;
    imm_type_e          imm_type;
    logic               illegal;
    logic               writes_rd;
    logic               uses_rs1;
    logic               uses_rs2;
    logic signed [31:0] imm_raw;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign funct5 = instr_i[31:27];

    function automatic logic signed [31:0] imm_gen(input logic [31:0] w, input imm_type_e t);
        case (t)
            IMM_I:   imm_gen = {{20{w[31]}}, w[31:20]};
            IMM_S:   imm_gen = {{20{w[31]}}, w[31:25], w[11:7]};
            IMM_B:   imm_gen = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            IMM_U:   imm_gen = {w[31:12], 12'h000};
            IMM_J:   imm_gen = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: imm_gen = '0;
        endcase
    endfunction

    always_comb begin
        base_uop        = '0;
        base_uop.rd     = instr_i[11:7];
        base_uop.rs1    = instr_i[19:15];
        base_uop.rs2    = instr_i[24:20];
        base_uop.funct3 = funct3;

        uop       = base_uop;
        imm_type  = IMM_NONE;
        illegal   = 1'b0;
        writes_rd = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;

        case (opcode)
            OPC_LUI: begin
                uop.fu_sel   = FU_ALU;
                uop.op_a_sel = OPA_ZERO;
                uop.op_b_sel = OPB_IMM;
                imm_type     = IMM_U;
                writes_rd    = 1'b1;
            end
            OPC_AUIPC: begin
                uop.fu_sel   = FU_ALU;
                uop.op_a_sel = OPA_PC;
                uop.op_b_sel = OPB_IMM;
                imm_type     = IMM_U;
                writes_rd    = 1'b1;
            end
            OPC_JAL: begin
                uop.fu_sel   = FU_BRU;
                uop.op_a_sel = OPA_PC;
                uop.op_b_sel = OPB_IMM;
                uop.jump     = 1'b1;
                imm_type     = IMM_J;
                writes_rd    = 1'b1;
            end
            OPC_JALR: begin
                uop.fu_sel   = FU_BRU;
                uop.op_b_sel = OPB_IMM;
                uop.jump     = 1'b1;
                imm_type     = IMM_I;
                writes_rd    = 1'b1;
                uses_rs1     = 1'b1;
                illegal      = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                uop.fu_sel = FU_BRU;
                uop.branch = 1'b1;
                imm_type   = IMM_B;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                // Equality compares subtract; ordered compares use SLT/SLTU.
                case (funct3[2:1])
                    2'b00:   uop.alu_op = ALU_SUB;
                    2'b10:   uop.alu_op = ALU_SLT;
                    2'b11:   uop.alu_op = ALU_SLTU;
                    default: illegal    = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                uop.fu_sel       = FU_LSU;
                uop.op_b_sel     = OPB_IMM;
                uop.mem_re       = 1'b1;
                uop.mem_size     = funct3[1:0];
                uop.mem_unsigned = funct3[2];
                imm_type         = IMM_I;
                writes_rd        = 1'b1;
                uses_rs1         = 1'b1;
                illegal          = (funct3 == 3'd3) || (funct3 >= 3'd6);
            end
            OPC_STORE: begin
                uop.fu_sel   = FU_LSU;
                uop.op_b_sel = OPB_IMM;
                uop.mem_we   = 1'b1;
                uop.mem_size = funct3[1:0];
                imm_type     = IMM_S;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
                illegal      = (funct3 > 3'd2);
            end
            OPC_OP_IMM: begin
                uop.fu_sel   = FU_ALU;
                uop.op_b_sel = OPB_IMM;
                uop.alu_op   = alu_op_e'({instr_i[30] & (funct3 == 3'd5), funct3});
                imm_type     = IMM_I;
                writes_rd    = 1'b1;
                uses_rs1     = 1'b1;
                if (funct3 == 3'd1)
                    illegal = (funct7 != 7'h00);
                else if (funct3 == 3'd5)
                    illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                if (funct7 == 7'h00) begin
                    uop.fu_sel = FU_ALU;
                    uop.alu_op = alu_op_e'({1'b0, funct3});
                end else if (funct7 == 7'h20) begin
                    uop.fu_sel = FU_ALU;
                    uop.alu_op = alu_op_e'({1'b1, funct3});
                    illegal    = (funct3 != 3'd0) && (funct3 != 3'd5);
                end else if ((funct7 == 7'h01) && HAS_M) begin
                    uop.fu_sel = funct3[2] ? FU_DIV : FU_MUL;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_AMO: begin
                // Every AMO reads memory, so it is treated as a load for hazards.
                uop.fu_sel   = FU_LSU;
                uop.op_b_sel = OPB_IMM;
                uop.mem_re   = 1'b1;
                uop.mem_we   = (funct5 != AMO_LR);
                uop.mem_size = 2'd2;
                writes_rd    = 1'b1;
                uses_rs1     = 1'b1;
                uses_rs2     = (funct5 != AMO_LR);
                illegal      = !HAS_A || (funct3 != 3'd2);
            end
            OPC_MISC_MEM: begin
                uop.fu_sel = FU_NONE;
            end
            OPC_SYSTEM: begin
                uop.fu_sel   = FU_CSR;
                uop.op_b_sel = OPB_IMM;
                imm_type     = IMM_I;
                writes_rd    = (funct3 != 3'd0);
                uses_rs1     = !funct3[2] && (funct3[1:0] != 2'b00);
            end
            default: illegal = 1'b1;
        endcase

        if (instr_i[1:0] != 2'b11)
            illegal = 1'b1;

        uop.rd_we = writes_rd && (instr_i[11:7] != 5'd0);

        // Illegal words travel as inert micro-ops carrying only register fields.
        if (illegal) begin
            uop      = base_uop;
            imm_type = IMM_NONE;
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
        end
    end

    assign imm_raw    = imm_gen(instr_i, imm_type);
    assign imm_o      = DATA_W'(imm_raw);
    assign uop_o      = uop;
    assign illegal_o  = illegal;
    assign uses_rs1_o = uses_rs1;
    assign uses_rs2_o = uses_rs2;

endmodule

// File: rtl/decode_stage.sv
// RV32I/M/A decode stage: decodes, reads operands, detects load-use hazards
// and drives the registered ID/EX boundary with valid/ready handshakes.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter bit HAS_M  = 1'b1,
    parameter bit HAS_A  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              if_valid_i,
    output logic              if_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic [4:0]        rf_raddr_a_o,
    output logic [4:0]        rf_raddr_b_o,
    input  logic [DATA_W-1:0] rf_a_i,
    input  logic [DATA_W-1:0] rf_b_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [UOP_W-1:0]  uop_o,
    output logic [DATA_W-1:0] rs1_val_o,
    output logic [DATA_W-1:0] rs2_val_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [DATA_W-1:0] pc_o,
    output logic              illegal_o,
    output logic              load_use_stall_o
);

    decoded_uop_t      dec_uop;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_illegal;
    logic              dec_uses_rs1;
    logic              dec_uses_rs2;
    logic              hazard;
    logic              accept;

    logic              vld_p1;
    decoded_uop_t      uop_p1;
    logic [DATA_W-1:0] rs1_val_p1;
    logic [DATA_W-1:0] rs2_val_p1;
    logic [DATA_W-1:0] imm_p1;
    logic [DATA_W-1:0] pc_p1;
    logic              illegal_p1;

    decode_comb #(
        .DATA_W (DATA_W),
        .HAS_M  (HAS_M),
        .HAS_A  (HAS_A)
    ) u_decode_comb (
        .instr_i    (instr_i),
        .uop_o      (dec_uop),
        .imm_o      (dec_imm),
        .illegal_o  (dec_illegal),
        .uses_rs1_o (dec_uses_rs1),
        .uses_rs2_o (dec_uses_rs2)
    );

    assign rf_raddr_a_o = instr_i[19:15];
    assign rf_raddr_b_o = instr_i[24:20];

    always_comb begin
        hazard = vld_p1 && uop_p1.mem_re && (uop_p1.rd != 5'd0) && if_valid_i &&
                 ((dec_uses_rs1 && (dec_uop.rs1 == uop_p1.rd)) ||
                  (dec_uses_rs2 && (dec_uop.rs2 == uop_p1.rd)));
    end

    assign if_ready_o       = (!vld_p1 || ex_ready_i) && !hazard;
    assign load_use_stall_o = hazard;
    assign accept           = if_valid_i && if_ready_o && !flush_i;

    // ---- ID -> EX boundary (p1) ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1 <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (ex_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            uop_p1     <= '0;
            rs1_val_p1 <= '0;
            rs2_val_p1 <= '0;
            imm_p1     <= '0;
            pc_p1      <= '0;
            illegal_p1 <= 1'b0;
        end else if (accept) begin
            uop_p1     <= dec_uop;
            rs1_val_p1 <= (dec_uop.rs1 == 5'd0) ? '0 : rf_a_i;
            rs2_val_p1 <= (dec_uop.rs2 == 5'd0) ? '0 : rf_b_i;
            imm_p1     <= dec_imm;
            pc_p1      <= pc_i;
            illegal_p1 <= dec_illegal;
        end
    end

    assign ex_valid_o = vld_p1;
    assign uop_o      = uop_p1;
    assign rs1_val_o  = rs1_val_p1;
    assign rs2_val_o  = rs2_val_p1;
    assign imm_o      = imm_p1;
    assign pc_o       = pc_p1;
    assign illegal_o  = illegal_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// stream compared every cycle against an instruction-level reference model.
`timescale 1ns/1ps
module tb_decode_stage;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        if_valid;
    logic        ex_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rf_a;
    logic [31:0] rf_b;

    logic         if_ready_w [2];
    logic         ex_valid_w [2];
    logic         ill_w      [2];
    logic         stall_w    [2];
    logic [4:0]   ra_w       [2];
    logic [4:0]   rb_w       [2];
    decoded_uop_t uop_w      [2];
    logic [31:0]  rs1_w      [2];
    logic [31:0]  rs2_w      [2];
    logic [31:0]  imm_w      [2];
    logic [31:0]  pc_w       [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           vld;
        decoded_uop_t uop;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  imm;
        logic [31:0]  pc;
        bit           ill;
    } mstate_t;

    mstate_t st [2];

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(32), .HAS_M(1'b1), .HAS_A(1'b1)) dut_full (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .if_valid_i(if_valid),
        .if_ready_o(if_ready_w[0]), .instr_i(instr), .pc_i(pc),
        .rf_raddr_a_o(ra_w[0]), .rf_raddr_b_o(rb_w[0]), .rf_a_i(rf_a), .rf_b_i(rf_b),
        .ex_valid_o(ex_valid_w[0]), .ex_ready_i(ex_ready), .uop_o(uop_w[0]),
        .rs1_val_o(rs1_w[0]), .rs2_val_o(rs2_w[0]), .imm_o(imm_w[0]), .pc_o(pc_w[0]),
        .illegal_o(ill_w[0]), .load_use_stall_o(stall_w[0])
    );

    decode_stage #(.DATA_W(32), .HAS_M(1'b0), .HAS_A(1'b0)) dut_base (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .if_valid_i(if_valid),
        .if_ready_o(if_ready_w[1]), .instr_i(instr), .pc_i(pc),
        .rf_raddr_a_o(ra_w[1]), .rf_raddr_b_o(rb_w[1]), .rf_a_i(rf_a), .rf_b_i(rf_b),
        .ex_valid_o(ex_valid_w[1]), .ex_ready_i(ex_ready), .uop_o(uop_w[1]),
        .rs1_val_o(rs1_w[1]), .rs2_val_o(rs2_w[1]), .imm_o(imm_w[1]), .pc_o(pc_w[1]),
        .illegal_o(ill_w[1]), .load_use_stall_o(stall_w[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference decoder: what each instruction must mean, by mnemonic class.
    function automatic void ref_decode(input logic [31:0] w, input bit hm, input bit ha,
                                       output decoded_uop_t u, output logic [31:0] imm,
                                       output bit ill, output bit u1, output bit u2);
        logic [2:0] f3;
        logic [6:0] f7;
        bit         we;
        bit         is_lr;
        f3    = w[14:12];
        f7    = w[31:25];
        is_lr = (w[31:27] == 5'b00010);
        u = '0; u.rd = w[11:7]; u.rs1 = w[19:15]; u.rs2 = w[24:20]; u.funct3 = f3;
        imm = 0; ill = 0; u1 = 0; u2 = 0; we = 0;
        case (w[6:0])
            OPC_LUI:   begin u.fu_sel = FU_ALU; u.op_a_sel = OPA_ZERO; u.op_b_sel = OPB_IMM;
                             imm = {w[31:12], 12'h0}; we = 1; end
            OPC_AUIPC: begin u.fu_sel = FU_ALU; u.op_a_sel = OPA_PC; u.op_b_sel = OPB_IMM;
                             imm = {w[31:12], 12'h0}; we = 1; end
            OPC_JAL:   begin u.fu_sel = FU_BRU; u.op_a_sel = OPA_PC; u.op_b_sel = OPB_IMM; u.jump = 1;
                             imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); we = 1; end
            OPC_JALR:  begin u.fu_sel = FU_BRU; u.op_b_sel = OPB_IMM; u.jump = 1; u1 = 1; we = 1;
                             imm = 32'($signed(w[31:20])); ill = (f3 != 0); end
            OPC_BRANCH: begin
                u.fu_sel = FU_BRU; u.branch = 1; u1 = 1; u2 = 1;
                imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                if (f3 == 0 || f3 == 1)      u.alu_op = ALU_SUB;
                else if (f3 == 4 || f3 == 5) u.alu_op = ALU_SLT;
                else if (f3 == 6 || f3 == 7) u.alu_op = ALU_SLTU;
                else                         ill = 1;
            end
            OPC_LOAD:  begin u.fu_sel = FU_LSU; u.op_b_sel = OPB_IMM; u.mem_re = 1; we = 1; u1 = 1;
                             u.mem_size = f3[1:0]; u.mem_unsigned = f3[2];
                             imm = 32'($signed(w[31:20])); ill = !(f3 inside {0, 1, 2, 4, 5}); end
            OPC_STORE: begin u.fu_sel = FU_LSU; u.op_b_sel = OPB_IMM; u.mem_we = 1; u1 = 1; u2 = 1;
                             u.mem_size = f3[1:0]; imm = 32'($signed({w[31:25], w[11:7]}));
                             ill = (f3 > 2); end
            OPC_OP_IMM: begin
                u.fu_sel = FU_ALU; u.op_b_sel = OPB_IMM; we = 1; u1 = 1;
                imm = 32'($signed(w[31:20]));
                u.alu_op = alu_op_e'({1'b0, f3});
                if (f3 == 5 && f7 == 7'h20) u.alu_op = ALU_SRA;
                if (f3 == 1 && f7 != 0) ill = 1;
                if (f3 == 5 && f7 != 0 && f7 != 7'h20) ill = 1;
            end
            OPC_OP: begin
                we = 1; u1 = 1; u2 = 1;
                if (f7 == 0) begin u.fu_sel = FU_ALU; u.alu_op = alu_op_e'({1'b0, f3}); end
                else if (f7 == 7'h20 && f3 == 0) begin u.fu_sel = FU_ALU; u.alu_op = ALU_SUB; end
                else if (f7 == 7'h20 && f3 == 5) begin u.fu_sel = FU_ALU; u.alu_op = ALU_SRA; end
                else if (f7 == 7'h01 && hm) u.fu_sel = (f3 >= 4) ? FU_DIV : FU_MUL;
                else ill = 1;
            end
            OPC_AMO: begin
                u.fu_sel = FU_LSU; u.op_b_sel = OPB_IMM; u.mem_re = 1; u.mem_we = !is_lr;
                u.mem_size = 2; we = 1; u1 = 1; u2 = !is_lr; ill = !ha || (f3 != 2);
            end
            OPC_MISC_MEM: ;
            OPC_SYSTEM: begin u.fu_sel = FU_CSR; u.op_b_sel = OPB_IMM; imm = 32'($signed(w[31:20]));
                              we = (f3 != 0); u1 = (f3 >= 1 && f3 <= 3); end
            default: ill = 1;
        endcase
        if (w[1:0] != 2'b11) ill = 1;
        u.rd_we = we && (w[11:7] != 0);
        if (ill) begin
            u = '0; u.rd = w[11:7]; u.rs1 = w[19:15]; u.rs2 = w[24:20]; u.funct3 = f3;
            imm = 0; u1 = 0; u2 = 0;
        end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            st[k].vld = 0; st[k].uop = '0; st[k].a = 0; st[k].b = 0;
            st[k].imm = 0; st[k].pc = 0; st[k].ill = 0;
        end
    endtask

    task automatic check_regs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d ex_valid", k), 64'(ex_valid_w[k]), 64'(st[k].vld));
            chk($sformatf("d%0d uop", k), 64'(uop_w[k]), 64'(st[k].uop));
            chk($sformatf("d%0d rs1_val", k), 64'(rs1_w[k]), 64'(st[k].a));
            chk($sformatf("d%0d rs2_val", k), 64'(rs2_w[k]), 64'(st[k].b));
            chk($sformatf("d%0d imm", k), 64'(imm_w[k]), 64'(st[k].imm));
            chk($sformatf("d%0d pc", k), 64'(pc_w[k]), 64'(st[k].pc));
            chk($sformatf("d%0d illegal", k), 64'(ill_w[k]), 64'(st[k].ill));
        end
    endtask

    // One clock: check combinational outputs, advance the model, check registers.
    task automatic cycle();
        mstate_t      nx [2];
        decoded_uop_t du;
        logic [31:0]  di;
        bit           dill, d1, d2, haz, rdy;
        #1;
        chk("raddr_a", 64'(ra_w[0]), 64'(instr[19:15]));
        chk("raddr_b", 64'(rb_w[0]), 64'(instr[24:20]));
        for (int k = 0; k < 2; k++) begin
            ref_decode(instr, k == 0, k == 0, du, di, dill, d1, d2);
            haz = st[k].vld && st[k].uop.mem_re && st[k].uop.rd != 0 && if_valid &&
                  ((d1 && instr[19:15] == st[k].uop.rd) || (d2 && instr[24:20] == st[k].uop.rd));
            rdy = (!st[k].vld || ex_ready) && !haz;
            chk($sformatf("d%0d if_ready", k), 64'(if_ready_w[k]), 64'(rdy));
            chk($sformatf("d%0d stall", k), 64'(stall_w[k]), 64'(haz));
            nx[k] = st[k];
            if (flush) nx[k].vld = 0;
            else if (if_valid && rdy) begin
                nx[k].vld = 1; nx[k].uop = du; nx[k].imm = di; nx[k].pc = pc; nx[k].ill = dill;
                nx[k].a = (instr[19:15] == 0) ? 32'h0 : rf_a;
                nx[k].b = (instr[24:20] == 0) ? 32'h0 : rf_b;
            end else if (ex_ready) nx[k].vld = 0;
        end
        @(posedge clk);
        #1;
        st = nx;
        check_regs();
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] p);
        instr = w; pc = p; if_valid = 1; rf_a = $urandom; rf_b = $urandom;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 12))
            0: w[6:0] = OPC_LOAD;     1: w[6:0] = OPC_STORE;  2: w[6:0] = OPC_OP;
            3: w[6:0] = OPC_OP_IMM;   4: w[6:0] = OPC_BRANCH; 5: w[6:0] = OPC_JAL;
            6: w[6:0] = OPC_JALR;     7: w[6:0] = OPC_LUI;    8: w[6:0] = OPC_AUIPC;
            9: w[6:0] = OPC_AMO;     10: w[6:0] = OPC_SYSTEM; 11: w[6:0] = OPC_MISC_MEM;
            default: ;
        endcase
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom_range(0, 2));
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; flush = 0; if_valid = 0; ex_ready = 1;
        instr = 0; pc = 0; rf_a = 0; rf_b = 0;
        model_reset();
        #12;
        chk("reset ex_valid", 64'(ex_valid_w[0]), 64'(0));
        chk("reset uop", 64'(uop_w[0]), 64'(0));
        chk("reset imm", 64'(imm_w[0]), 64'(0));
        chk("reset pc", 64'(pc_w[0]), 64'(0));
        rst_n = 1;
        @(posedge clk);
        #1;

        // Scenario 1: ADDI x1,x0,5
        drive(32'h00500093, 32'h100); ex_ready = 1;
        cycle();
        chk("s1 ex_valid", 64'(ex_valid_w[0]), 64'(1));
        chk("s1 imm", 64'(imm_w[0]), 64'h5);
        chk("s1 rd", 64'(uop_w[0].rd), 64'd1);
        chk("s1 rd_we", 64'(uop_w[0].rd_we), 64'd1);
        chk("s1 fu_sel", 64'(uop_w[0].fu_sel), 64'(FU_ALU));
        chk("s1 op_b_sel", 64'(uop_w[0].op_b_sel), 64'(OPB_IMM));
        chk("s1 pc", 64'(pc_w[0]), 64'h100);

        // Scenario 2: backpressure holds everything
        ex_ready = 0; drive(32'h00108333, 32'h104);
        repeat (3) begin
            #1 chk("s2 if_ready", 64'(if_ready_w[0]), 64'd0);
            cycle();
            chk("s2 hold pc", 64'(pc_w[0]), 64'h100);
            chk("s2 hold imm", 64'(imm_w[0]), 64'h5);
        end
        ex_ready = 1;
        cycle();
        chk("s2 issue pc", 64'(pc_w[0]), 64'h104);
        chk("s2 issue rd", 64'(uop_w[0].rd), 64'd6);

        // Scenario 3: load-use hazard, then an independent consumer
        drive(32'h00012283, 32'h200);
        cycle();
        drive(32'h00528333, 32'h204);
        #1 chk("s3 stall", 64'(stall_w[0]), 64'd1);
        cycle();
        chk("s3 bubble", 64'(ex_valid_w[0]), 64'd0);
        #1 chk("s3 stall cleared", 64'(stall_w[0]), 64'd0);
        cycle();
        chk("s3 issue", 64'(ex_valid_w[0]), 64'd1);
        chk("s3 issue pc", 64'(pc_w[0]), 64'h204);
        drive(32'h00012283, 32'h208);
        cycle();
        drive(32'h00108333, 32'h20C);
        #1 chk("s3 no stall", 64'(stall_w[0]), 64'd0);
        cycle();
        chk("s3 no bubble pc", 64'(pc_w[0]), 64'h20C);

        // Scenario 4: MUL with and without RV32M, unknown opcode
        drive(32'h022081B3, 32'h300);
        cycle();
        chk("s4 mul fu", 64'(uop_w[0].fu_sel), 64'(FU_MUL));
        chk("s4 mul rd", 64'(uop_w[0].rd), 64'd3);
        chk("s4 mul legal", 64'(ill_w[0]), 64'd0);
        chk("s4 noM illegal", 64'(ill_w[1]), 64'd1);
        chk("s4 noM rd_we", 64'(uop_w[1].rd_we), 64'd0);
        chk("s4 noM fu", 64'(uop_w[1].fu_sel), 64'(FU_NONE));
        drive(32'h0000007F, 32'h304);
        cycle();
        chk("s4 unknown illegal", 64'(ill_w[0]), 64'd1);

        // Scenario 5: BEQ immediate, then flush drops a concurrent accept
        drive(32'hFE000EE3, 32'h400);
        cycle();
        chk("s5 beq imm", 64'(imm_w[0]), 64'hFFFFFFFC);
        chk("s5 beq branch", 64'(uop_w[0].branch), 64'd1);
        drive(32'h00500093, 32'h404); flush = 1;
        cycle();
        chk("s5 flush ex_valid", 64'(ex_valid_w[0]), 64'd0);
        flush = 0;

        // Scenario 6: asynchronous reset during backpressure
        ex_ready = 0; drive(32'h00500093, 32'h500);
        cycle();
        drive(32'h00108333, 32'h504);
        cycle();
        #2 rst_n = 0;
        #1;
        chk("s6 rst ex_valid", 64'(ex_valid_w[0]), 64'd0);
        chk("s6 rst imm", 64'(imm_w[0]), 64'd0);
        chk("s6 rst pc", 64'(pc_w[0]), 64'd0);
        chk("s6 rst rs1", 64'(rs1_w[0]), 64'd0);
        model_reset();
        if_valid = 0;
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        drive(32'h00500093, 32'h100); ex_ready = 1;
        cycle();
        chk("s6 re ex_valid", 64'(ex_valid_w[0]), 64'd1);
        chk("s6 re imm", 64'(imm_w[0]), 64'h5);
        chk("s6 re pc", 64'(pc_w[0]), 64'h100);

        // Randomized stream
        repeat (800) begin
            instr    = rand_instr();
            pc       = $urandom & 32'hFFFF_FFFC;
            rf_a     = $urandom;
            rf_b     = $urandom;
            if_valid = ($urandom_range(0, 9) < 8);
            ex_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
